// File: rtl/icb_mem_pkg.sv
// Shared types and constants for the ICB memory responder slice.
package icb_mem_pkg;

  localparam int unsigned ICB_DATA_WIDTH      = 32;
  localparam int unsigned ICB_OUTSTANDING_MAX = 2;

  typedef struct packed {
    logic [ICB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } icb_rsp_entry_t;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Two-entry first-word-fall-through buffer holding ICB responses in command order.
module icb_rsp_fifo
  import icb_mem_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  icb_rsp_entry_t push_entry,
  input  logic           pop,
  output logic           valid,
  output icb_rsp_entry_t head
);

  localparam int unsigned PTR_W = $clog2(ICB_OUTSTANDING_MAX);
  localparam int unsigned CNT_W = $clog2(ICB_OUTSTANDING_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ICB_OUTSTANDING_MAX);

  icb_rsp_entry_t   entries_q [ICB_OUTSTANDING_MAX];
  icb_rsp_entry_t   entries_d [ICB_OUTSTANDING_MAX];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count_q < CNT_MAX);
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok) begin
      entries_d[wr_ptr_q] = push_entry;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ICB_OUTSTANDING_MAX; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign head  = entries_q[rd_ptr_q];

endmodule

// File: rtl/icb_mem_responder.sv
// ICB slave backed by an inferred word memory, 1-cycle response latency, up to 2 in flight.
// Define ICB_MEM_RESPONDER_MISALIGN_ERR_EN to reject addresses not aligned to the word size.
module icb_mem_responder
  import icb_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ICB_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    icb_cmd_valid,
  output logic                    icb_cmd_ready,
  input  logic                    icb_cmd_read,
  input  logic [31:0]             icb_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   icb_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] icb_cmd_wmask,
  output logic                    icb_rsp_valid,
  input  logic                    icb_rsp_ready,
  output logic [DATA_WIDTH-1:0]   icb_rsp_rdata,
  output logic                    icb_rsp_err,
  output logic [1:0]              outstanding
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [1:0]  OUT_MAX  = 2'(ICB_OUTSTANDING_MAX);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [1:0]       outstanding_q, outstanding_d;
  logic [31:0]      addr_off, word_off;
  logic [IDX_W-1:0] word_idx;
  logic             in_range, misalign, access_ok;
  logic             cmd_hs, rsp_hs, mem_we;
  logic             fifo_valid;
  icb_rsp_entry_t   rsp_entry, rsp_head;

  // Ready depends only on the registered count, so no valid/ready loop exists.
  assign icb_cmd_ready = (outstanding_q < OUT_MAX);
  assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
  assign rsp_hs        = fifo_valid && icb_rsp_ready;

  assign addr_off = icb_cmd_addr - BASE_ADDR;
  assign word_off = addr_off >> ADDR_LSB;
  assign word_idx = word_off[IDX_W-1:0];
  assign in_range = (icb_cmd_addr >= BASE_ADDR) && (word_off < MEM_DEPTH);

`ifdef ICB_MEM_RESPONDER_MISALIGN_ERR_EN
  assign misalign = |icb_cmd_addr[ADDR_LSB-1:0];
`else
  assign misalign = 1'b0;
`endif

  assign access_ok = in_range && !misalign;
  assign mem_we    = cmd_hs && !icb_cmd_read && access_ok;

  always_comb begin
    rsp_entry       = '0;
    rsp_entry.err   = !access_ok;
    if (icb_cmd_read && access_ok) begin
      rsp_entry.rdata = mem_q[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (icb_cmd_wmask[b]) begin
          mem_q[word_idx][b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({cmd_hs, rsp_hs})
      2'b10:   outstanding_d = outstanding_q + 2'd1;
      2'b01:   outstanding_d = outstanding_q - 2'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  icb_rsp_fifo u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (cmd_hs),
    .push_entry (rsp_entry),
    .pop        (rsp_hs),
    .valid      (fifo_valid),
    .head       (rsp_head)
  );

  assign outstanding   = outstanding_q;
  assign icb_rsp_valid = fifo_valid;
  assign icb_rsp_rdata = fifo_valid ? rsp_head.rdata : '0;
  assign icb_rsp_err   = fifo_valid && rsp_head.err;

endmodule

// File: tb/tb_icb_mem_responder.sv
// Directed self-checking bench for icb_mem_responder.
module tb_icb_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic [1:0]  outstanding;

  icb_mem_responder #(
    .DATA_WIDTH (32),
    .MEM_DEPTH  (1024),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .outstanding   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic last_acc;

  // Drive one command for one cycle; last_acc records whether ready was high at the edge.
  task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    @(negedge clk);
    last_acc = icb_cmd_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icb_cmd_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    icb_rsp_ready = 1'b1;
    #12;
    checks++; if (icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", icb_cmd_ready); end
    checks++; if (icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", icb_rsp_valid); end
    checks++; if (icb_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", icb_rsp_rdata); end
    checks++; if (icb_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", icb_rsp_err); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    icb_rsp_ready = 1'b1;
    issue(1'b0, BASE, 32'hDEAD_BEEF, 4'hF);
    checks++; if (last_acc !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", last_acc); end
    checks++; if (icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid got %b want 1", icb_rsp_valid); end
    checks++; if (icb_rsp_rdata !== 32'h0 || icb_rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp got %h/%b want 0/0", icb_rsp_rdata, icb_rsp_err); end
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL wr_outstanding got %0d want 1", outstanding); end
    issue(1'b1, BASE, 32'h0, 4'h0);
    checks++; if (icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_latency rsp_valid got %b want 1", icb_rsp_valid); end
    checks++; if (icb_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", icb_rsp_rdata); end
    checks++; if (icb_rsp_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", icb_rsp_err); end
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL simul_hs_outstanding got %0d want 1", outstanding); end
    idle();
    checks++; if (icb_rsp_valid !== 1'b0 || outstanding !== 2'd0) begin errors++; $display("FAIL drain got %b/%0d want 0/0", icb_rsp_valid, outstanding); end
  endtask

  task automatic test_byte_mask();
    icb_rsp_ready = 1'b1;
    issue(1'b0, BASE + 32'h4, 32'h1122_3344, 4'hF);
    issue(1'b0, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101);
    issue(1'b0, BASE + 32'h4, 32'hFFFF_FFFF, 4'h0);
    checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0) begin errors++; $display("FAIL mask0_rsp got %b/%b want 1/0", icb_rsp_valid, icb_rsp_err); end
    issue(1'b1, BASE + 32'h4, 32'h0, 4'h0);
    checks++; if (icb_rsp_rdata !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_mask got %h want 11bb33dd", icb_rsp_rdata); end
    idle();
  endtask

  task automatic test_out_of_range();
    icb_rsp_ready = 1'b1;
    issue(1'b1, BASE + 32'h1000, 32'h0, 4'h0);
    checks++; if (icb_rsp_err !== 1'b1 || icb_rsp_rdata !== 32'h0) begin errors++; $display("FAIL oor_read got %b/%h want 1/0", icb_rsp_err, icb_rsp_rdata); end
    issue(1'b0, BASE + 32'h1000, 32'h5555_5555, 4'hF);
    checks++; if (icb_rsp_err !== 1'b1) begin errors++; $display("FAIL oor_write_err got %b want 1", icb_rsp_err); end
    issue(1'b1, BASE - 32'h4, 32'h0, 4'h0);
    checks++; if (icb_rsp_err !== 1'b1) begin errors++; $display("FAIL below_base_err got %b want 1", icb_rsp_err); end
    issue(1'b0, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF);
    checks++; if (icb_rsp_err !== 1'b0) begin errors++; $display("FAIL last_word_write_err got %b want 0", icb_rsp_err); end
    issue(1'b1, BASE + 32'hFFC, 32'h0, 4'h0);
    checks++; if (icb_rsp_rdata !== 32'hCAFE_F00D || icb_rsp_err !== 1'b0) begin errors++; $display("FAIL last_word_read got %h/%b want cafef00d/0", icb_rsp_rdata, icb_rsp_err); end
    issue(1'b1, BASE, 32'h0, 4'h0);
    checks++; if (icb_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_no_alias got %h want deadbeef", icb_rsp_rdata); end
    idle();
  endtask

  task automatic test_misalign();
    logic [31:0] exp_data;
    logic        exp_err;
`ifdef ICB_MEM_RESPONDER_MISALIGN_ERR_EN
    exp_data = 32'h0;
    exp_err  = 1'b1;
`else
    exp_data = 32'hDEAD_BEEF;
    exp_err  = 1'b0;
`endif
    icb_rsp_ready = 1'b1;
    issue(1'b1, BASE + 32'h2, 32'h0, 4'h0);
    checks++; if (icb_rsp_rdata !== exp_data || icb_rsp_err !== exp_err) begin errors++; $display("FAIL misalign got %h/%b want %h/%b", icb_rsp_rdata, icb_rsp_err, exp_data, exp_err); end
    idle();
  endtask

  task automatic test_back_to_back();
    int  acc_count;
    int  max_out;
    time t0;
    logic [31:0] exp;
    acc_count = 0;
    max_out   = 0;
    icb_rsp_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, BASE + 32'h40 + 32'(4 * i), 32'hA5A5_0000 + 32'(i * 32'h111), 4'hF);
      if (last_acc === 1'b1) acc_count++;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, BASE + 32'h40 + 32'(4 * i), 32'h0, 4'h0);
      if (last_acc === 1'b1) acc_count++;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      exp = 32'hA5A5_0000 + 32'(i * 32'h111);
      checks++; if (icb_rsp_rdata !== exp || icb_rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_read%0d got %h/%b want %h/0", i, icb_rsp_rdata, icb_rsp_err, exp); end
    end
    checks++; if (acc_count != 16) begin errors++; $display("FAIL b2b_accepts got %0d want 16", acc_count); end
    checks++; if (($time - t0) != 160) begin errors++; $display("FAIL b2b_duration got %0t want 160", $time - t0); end
    checks++; if (max_out > 1) begin errors++; $display("FAIL b2b_max_outstanding got %0d want <=1", max_out); end
    idle();
  endtask

  task automatic test_backpressure();
    icb_rsp_ready = 1'b0;
    issue(1'b1, BASE + 32'h40, 32'h0, 4'h0);
    checks++; if (last_acc !== 1'b1 || outstanding !== 2'd1) begin errors++; $display("FAIL bp_first got %b/%0d want 1/1", last_acc, outstanding); end
    issue(1'b1, BASE + 32'h44, 32'h0, 4'h0);
    checks++; if (last_acc !== 1'b1 || outstanding !== 2'd2) begin errors++; $display("FAIL bp_second got %b/%0d want 1/2", last_acc, outstanding); end
    checks++; if (icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", icb_cmd_ready); end
    issue(1'b1, BASE + 32'h48, 32'h0, 4'h0);
    checks++; if (last_acc !== 1'b0 || outstanding !== 2'd2) begin errors++; $display("FAIL bp_third_blocked got %b/%0d want 0/2", last_acc, outstanding); end
    checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_hold got %b/%h want 1/a5a50000", icb_rsp_valid, icb_rsp_rdata); end
    icb_rsp_ready = 1'b1;
    issue(1'b1, BASE + 32'h48, 32'h0, 4'h0);
    checks++; if (last_acc !== 1'b0) begin errors++; $display("FAIL bp_ready_registered got %b want 0", last_acc); end
    checks++; if (icb_rsp_rdata !== 32'hA5A5_0111 || outstanding !== 2'd1) begin errors++; $display("FAIL bp_order_b got %h/%0d want a5a50111/1", icb_rsp_rdata, outstanding); end
    issue(1'b1, BASE + 32'h48, 32'h0, 4'h0);
    checks++; if (last_acc !== 1'b1) begin errors++; $display("FAIL bp_third_accept got %b want 1", last_acc); end
    checks++; if (icb_rsp_rdata !== 32'hA5A5_0222 || outstanding !== 2'd1) begin errors++; $display("FAIL bp_order_c got %h/%0d want a5a50222/1", icb_rsp_rdata, outstanding); end
    idle();
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL bp_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_reset_mid();
    icb_rsp_ready = 1'b0;
    issue(1'b1, BASE, 32'h0, 4'h0);
    issue(1'b1, BASE + 32'h4, 32'h0, 4'h0);
    icb_cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (icb_cmd_ready !== 1'b1 || icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_hs got %b/%b want 1/0", icb_cmd_ready, icb_rsp_valid); end
    checks++; if (icb_rsp_rdata !== 32'h0 || icb_rsp_err !== 1'b0 || outstanding !== 2'd0) begin errors++; $display("FAIL midrst_state got %h/%b/%0d want 0/0/0", icb_rsp_rdata, icb_rsp_err, outstanding); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard got %b want 0", icb_rsp_valid); end
    icb_rsp_ready = 1'b1;
    issue(1'b1, BASE + 32'h4, 32'h0, 4'h0);
    checks++; if (icb_rsp_rdata !== 32'h11BB_33DD) begin errors++; $display("FAIL midrst_mem_kept got %h want 11bb33dd", icb_rsp_rdata); end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_out_of_range();
    test_misalign();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icb_mem_responder.md
ICB_MEM_RESPONDER -- requirements
Module: icb_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of the data port.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, number of DATA_WIDTH words in the backing store.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port icb_cmd_valid  input  1  command valid from initiator.
REQ-007 SHALL have port icb_cmd_ready  output  1  command accepted when valid and ready both high.
REQ-008 SHALL have port icb_cmd_read  input  1  1 = read, 0 = write.
REQ-009 SHALL have port icb_cmd_addr  input  32  byte address.
REQ-010 SHALL have port icb_cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port icb_cmd_wmask  input  DATA_WIDTH/8  byte write enables.
REQ-012 SHALL have port icb_rsp_valid  output  1  response valid.
REQ-013 SHALL have port icb_rsp_ready  input  1  initiator accepts response.
REQ-014 SHALL have port icb_rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 SHALL have port icb_rsp_err  output  1  access error flag.
REQ-016 SHALL have port outstanding  output  2  accepted commands whose response is not yet handshaken.

Function
REQ-017 SHALL decode word index = (icb_cmd_addr - BASE_ADDR) >> log2(DATA_WIDTH/8); in range iff icb_cmd_addr >= BASE_ADDR and index < MEM_DEPTH.
REQ-018 SHALL drive icb_cmd_ready = (outstanding < 2), from registered state only, with no combinational path from icb_rsp_ready or icb_cmd_valid.
REQ-019 SHALL, on in-range write handshake, update only the bytes whose wmask bit is 1; wmask = 0 is a legal no-op write that still returns a response with err = 0.
REQ-020 SHALL, on in-range read handshake, return the stored word, including any write accepted in an earlier cycle.
REQ-021 SHALL, on out-of-range handshake, not access memory and respond with err = 1 and rdata = 0.
REQ-022 SHALL raise icb_rsp_valid at the earliest in the cycle after the command handshake (1-cycle latency).
REQ-023 SHALL return responses strictly in command order, buffering up to 2 responses.
REQ-024 SHALL hold rsp_valid, rdata and err stable while rsp_valid = 1 and rsp_ready = 0.
REQ-025 SHALL sustain one command per cycle while rsp_ready stays 1.
REQ-026 SHALL update outstanding as follows: +1 on command handshake only, -1 on response handshake only, unchanged when both occur in the same cycle.

Reset
REQ-027 SHALL, while rst_n = 0, force icb_cmd_ready = 1, icb_rsp_valid = 0, icb_rsp_rdata = 0, icb_rsp_err = 0, outstanding = 0.
REQ-028 SHALL, on reset mid-transaction, discard buffered responses; memory contents are undefined after reset and are not cleared.

Configuration
REQ-029 SHALL support macro ICB_MEM_RESPONDER_MISALIGN_ERR_EN: when defined, an address not aligned to DATA_WIDTH/8 bytes responds with err = 1 and rdata = 0 and does not access memory.
REQ-030 SHALL, when ICB_MEM_RESPONDER_MISALIGN_ERR_EN is undefined, ignore the low address bits and perform a normal access.

Structure
REQ-031 SHALL take the response-entry typedef {rdata, err} and the outstanding-depth constant (2) from shared package icb_mem_pkg.
REQ-032 SHALL implement response buffering in one sub-module, icb_rsp_fifo (2-entry, first-word-fall-through); the memory array is inferred in the top.

Verification
REQ-033 Write 0xDEADBEEF at 0x1000_0000 with wmask 4'hF, then read the same address -> read rsp rdata = 0xDEADBEEF, err = 0, rsp_valid high 1 cycle after the read handshake.
REQ-034 Write 0x11223344 with wmask 4'hF, then write 0xAABBCCDD with wmask 4'b0101, then read -> rdata = 0x11BB33DD.
REQ-035 Read 0x1000_1000 (index 1024) -> err = 1, rdata = 0; memory unchanged.
REQ-036 Hold rsp_ready = 0 and issue 3 back-to-back reads -> 2 accepted, cmd_ready = 0 and outstanding = 2; after rsp_ready = 1, responses arrive in order and the 3rd command is accepted.
REQ-037 Keep rsp_ready = 1 and issue 8 back-to-back writes then 8 reads -> 16 accepts in 16 cycles, data matches, outstanding never exceeds 1.
REQ-038 Read 0x1000_0002 -> err = 1 with ICB_MEM_RESPONDER_MISALIGN_ERR_EN defined; word 0 data with err = 0 without it.
